// File: rtl/mux2x1_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 mux select with a registered shared output.
// Optional per-holder grant limit: define MUX2X1_ARB_HOLD_LIMIT_EN.
module mux2x1_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_a;    // 1: A was the most recent holder, 0: B
  logic   hold_hit;  // current holder has used up its grant budget

  if (MAX_HOLD == 0 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux2x1_arbiter: MAX_HOLD must be in 1..255");
  end

`ifdef MUX2X1_ARB_HOLD_LIMIT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  // Counter reaches MAX_HOLD on this edge, so this is the holder's last cycle.
  assign hold_hit = (hold_cnt >= HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state_next != IDLE && state_next != state) begin
      hold_cnt <= '0;
    end else if (state != IDLE && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: tie goes to the requester that did not hold last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !last_a)) begin
          state_next = GNT_A;
        end else if (req_b) begin
          state_next = GNT_B;
        end
      end
      GNT_A: begin
        if (!req_a) begin
          state_next = req_b ? GNT_B : IDLE;
        end else if (req_b && hold_hit) begin
          state_next = GNT_B;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_next = req_a ? GNT_A : IDLE;
        end else if (req_a && hold_hit) begin
          state_next = GNT_A;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered grants, select, round-robin pointer and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_a  <= 1'b0;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      s       <= 1'b1;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      if (state == GNT_A && state_next != GNT_A) begin
        last_a <= 1'b1;
      end else if (state == GNT_B && state_next != GNT_B) begin
        last_a <= 1'b0;
      end
      gnt_a <= (state_next == GNT_A);
      gnt_b <= (state_next == GNT_B);
      if (state_next == GNT_A) begin
        s <= 1'b1;
      end else if (state_next == GNT_B) begin
        s <= 1'b0;
      end
      y_valid <= (state != IDLE);
      if (state != IDLE) begin
        y <= s ? a : b;
      end
    end
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Self-checking bench for mux2x1_arbiter: table-driven scenarios with a data scoreboard.
module tb_mux2x1_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;
`ifdef MUX2X1_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [WIDTH-1:0] a, b, y;
  logic             gnt_a, gnt_b, s, y_valid;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb [$];
  logic exp_s;

  always #5 clk = ~clk;

  mux2x1_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .s(s), .y(y), .y_valid(y_valid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges; bench model returns to reset state.
  task automatic pulse_reset();
    req_a = 1'b0;
    req_b = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    sb.delete();
    exp_s = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt_a, gnt_b, s, y_valid, y} !== {4'b0010, 8'h00}) begin
      errors++;
      $display("FAIL reset_async got %b want %b", {gnt_a, gnt_b, s, y_valid, y}, {4'b0010, 8'h00});
    end
    for (int i = 0; i < 4; i++) begin
      req_a = 1'($urandom); req_b = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom);
      cyc();
      checks++;
      if ({gnt_a, gnt_b, s, y_valid, y} !== {4'b0010, 8'h00}) begin
        errors++;
        $display("FAIL reset_held cyc %0d got %b want %b", i, {gnt_a, gnt_b, s, y_valid, y}, {4'b0010, 8'h00});
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    rst = 1'b0;
    sb.delete();
    exp_s = 1'b1;
  endtask

  // Rows are {req_a, req_b, expected gnt_a, expected gnt_b}.
  task automatic test_single();
    logic [3:0] rows [$];
    logic [WIDTH-1:0] e;
    pulse_reset();
    a = 8'h5A; b = 8'hE7;
    rows = '{4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
    foreach (rows[k]) begin
      {req_a, req_b} = rows[k][3:2];
      cyc();
      if (rows[k][1]) exp_s = 1'b1; else if (rows[k][0]) exp_s = 1'b0;
      checks++;
      if ({gnt_a, gnt_b, s, y_valid} !== {rows[k][1:0], exp_s, sb.size() != 0}) begin
        errors++;
        $display("FAIL single ctrl row %0d got %b want %b", k, {gnt_a, gnt_b, s, y_valid}, {rows[k][1:0], exp_s, sb.size() != 0});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (y !== e) begin errors++; $display("FAIL single y row %0d got %h want %h", k, y, e); end
      end
      if (rows[k][1]) sb.push_back(a); else if (rows[k][0]) sb.push_back(b);
    end
  endtask

  task automatic test_tie();
    logic [3:0] rows [$];
    logic [WIDTH-1:0] e;
    pulse_reset();
    a = 8'hA1; b = 8'hB2;
    rows = '{4'b1110, 4'b1110, 4'b0101, 4'b0101, 4'b0000,
             4'b1110, 4'b1010, 4'b0000, 4'b0000};
    foreach (rows[k]) begin
      {req_a, req_b} = rows[k][3:2];
      cyc();
      if (rows[k][1]) exp_s = 1'b1; else if (rows[k][0]) exp_s = 1'b0;
      checks++;
      if ({gnt_a, gnt_b, s, y_valid} !== {rows[k][1:0], exp_s, sb.size() != 0}) begin
        errors++;
        $display("FAIL tie ctrl row %0d got %b want %b", k, {gnt_a, gnt_b, s, y_valid}, {rows[k][1:0], exp_s, sb.size() != 0});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (y !== e) begin errors++; $display("FAIL tie y row %0d got %h want %h", k, y, e); end
      end
      if (rows[k][1]) sb.push_back(a); else if (rows[k][0]) sb.push_back(b);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rows [$];
    logic [WIDTH-1:0] e;
    a = 8'h11; b = 8'h22;
    rows = '{4'b1010, 4'b1010, 4'b0101, 4'b0000, 4'b1010,
             4'b0000, 4'b1101, 4'b0000, 4'b0000};
    foreach (rows[k]) begin
      {req_a, req_b} = rows[k][3:2];
      cyc();
      if (rows[k][1]) exp_s = 1'b1; else if (rows[k][0]) exp_s = 1'b0;
      checks++;
      if ({gnt_a, gnt_b, s, y_valid} !== {rows[k][1:0], exp_s, sb.size() != 0}) begin
        errors++;
        $display("FAIL b2b ctrl row %0d got %b want %b", k, {gnt_a, gnt_b, s, y_valid}, {rows[k][1:0], exp_s, sb.size() != 0});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (y !== e) begin errors++; $display("FAIL b2b y row %0d got %h want %h", k, y, e); end
      end
      if (rows[k][1]) sb.push_back(a); else if (rows[k][0]) sb.push_back(b);
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] rows [$];
    logic [WIDTH-1:0] e;
    logic ph;
    pulse_reset();
    a = 8'hC3; b = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      ph = ((k / 4) % 2 == 0);
      rows.push_back({2'b11, HOLD_EN ? ph : 1'b1, HOLD_EN ? !ph : 1'b0});
    end
    rows.push_back(4'b0000);
    for (int k = 0; k < 7; k++) rows.push_back(4'b1010);
    rows.push_back(HOLD_EN ? 4'b1101 : 4'b1110);
    rows.push_back(4'b0101);
    rows.push_back(4'b0000);
    rows.push_back(4'b0000);
    foreach (rows[k]) begin
      {req_a, req_b} = rows[k][3:2];
      cyc();
      if (rows[k][1]) exp_s = 1'b1; else if (rows[k][0]) exp_s = 1'b0;
      checks++;
      if ({gnt_a, gnt_b, s, y_valid} !== {rows[k][1:0], exp_s, sb.size() != 0}) begin
        errors++;
        $display("FAIL hold ctrl row %0d got %b want %b", k, {gnt_a, gnt_b, s, y_valid}, {rows[k][1:0], exp_s, sb.size() != 0});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (y !== e) begin errors++; $display("FAIL hold y row %0d got %h want %h", k, y, e); end
      end
      if (rows[k][1]) sb.push_back(a); else if (rows[k][0]) sb.push_back(b);
    end
  endtask

  task automatic test_mid_reset();
    logic [WIDTH-1:0] e;
    pulse_reset();
    a = 8'h9D; b = 8'h4B;
    req_b = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({gnt_a, gnt_b, s, y_valid, y} !== {4'b0101, 8'h4B}) begin
      errors++;
      $display("FAIL midrst pre got %b want %b", {gnt_a, gnt_b, s, y_valid, y}, {4'b0101, 8'h4B});
    end
    req_a = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt_a, gnt_b, s, y_valid, y} !== {4'b0010, 8'h00}) begin
      errors++;
      $display("FAIL midrst async got %b want %b", {gnt_a, gnt_b, s, y_valid, y}, {4'b0010, 8'h00});
    end
    #2 rst = 1'b0;
    sb.delete();
    cyc();
    checks++;
    if ({gnt_a, gnt_b, s, y_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL midrst regrant got %b want %b", {gnt_a, gnt_b, s, y_valid}, 4'b1010);
    end
    sb.push_back(a);
    req_a = 1'b0; req_b = 1'b0;
    cyc();
    e = sb.pop_front();
    checks++;
    if ({gnt_a, gnt_b, y_valid, y} !== {3'b001, e}) begin
      errors++;
      $display("FAIL midrst data got %b want %b", {gnt_a, gnt_b, y_valid, y}, {3'b001, e});
    end
    cyc();
    checks++;
    if ({gnt_a, gnt_b, s, y_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL midrst idle got %b want %b", {gnt_a, gnt_b, s, y_valid}, 4'b0010);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_hold_limit();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
